// File: rtl/opb_slave_window_ctrl_if.sv
// OPB bus-side signal bundle for the shared register window controller.
// A transfer runs while OPB_select is high; the slave ends it with a one-cycle
// Sl_xferAck (data valid on Sl_DBus for reads) or Sl_errAck pulse. Dropping
// OPB_select before either pulse is an abort: no acknowledge is returned.
interface opb_slave_window_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [0:AW-1]   OPB_ABus;
  logic [0:DW/8-1] OPB_BE;
  logic [0:DW-1]   OPB_DBus;
  logic            OPB_RNW;
  logic            OPB_select;
  logic            OPB_seqAddr;

  logic [0:DW-1]   Sl_DBus;
  logic            Sl_xferAck;
  logic            Sl_errAck;
  logic            Sl_retry;
  logic            Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_slave_window_ctrl.sv
// Shares one OPB address window between NUM_SLAVES register slaves: decodes,
// forwards to one sub-slave, returns its ack/data, and times out hung slaves.
module opb_slave_window_ctrl #(
  parameter logic [31:0] C_BASEADDR     = 32'h0108C000,
  parameter int          NUM_SLAVES     = 4,
  parameter int          REGION_SHIFT   = 8,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          C_OPB_AWIDTH   = 32,
  parameter int          C_OPB_DWIDTH   = 32
) (
  input  logic                                OPB_Clk,
  input  logic                                OPB_Rst,
  opb_slave_window_ctrl_if.slave              opb,
  output logic [NUM_SLAVES-1:0]               sub_select,
  output logic [0:C_OPB_AWIDTH-1]             sub_ABus,
  output logic [0:C_OPB_DWIDTH-1]             sub_DBus,
  output logic [0:C_OPB_DWIDTH/8-1]           sub_BE,
  output logic                                sub_RNW,
  input  logic [NUM_SLAVES*C_OPB_DWIDTH-1:0]  sub_rdata,
  input  logic [NUM_SLAVES-1:0]               sub_xferAck,
  input  logic [NUM_SLAVES-1:0]               sub_errAck,
  output logic [15:0]                         timeout_count,
  input  logic                                tc_load,
  input  logic [15:0]                         tc_load_value,
  output logic [1:0]                          state_dbg
);

  localparam int AW    = C_OPB_AWIDTH;
  localparam int DW    = C_OPB_DWIDTH;
  localparam int BW    = C_OPB_DWIDTH / 8;
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  localparam logic [AW-1:0] BASE      = AW'(C_BASEADDR);
  localparam logic [AW:0]   WIN_BYTES = (AW + 1)'(NUM_SLAVES) << REGION_SHIFT;
  localparam logic [7:0]    TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       timer_q, timer_d;
  logic             armed_q, armed_d;
  logic [AW-1:0]    abus_d;
  logic [DW-1:0]    dbus_d;
  logic [BW-1:0]    be_d;
  logic             rnw_d;
  logic             xfer_ack_q, xfer_ack_d;
  logic             err_ack_q, err_ack_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [15:0]      tcount_d;

  // Address decode, evaluated every cycle on the live bus
  logic [AW-1:0]    abus_v;
  logic [AW-1:0]    offset;
  logic             in_win;
  logic [IDX_W-1:0] dec_idx;

  assign abus_v  = opb.OPB_ABus;
  assign offset  = abus_v - BASE;
  assign in_win  = (abus_v >= BASE) && ({1'b0, offset} < WIN_BYTES);
  assign dec_idx = IDX_W'(offset >> REGION_SHIFT);

  // Only the selected sub-slave's responses matter; others are ignored
  logic          sel_ack;
  logic          sel_err;
  logic [DW-1:0] sel_rdata;

  assign sel_ack   = sub_xferAck[idx_q];
  assign sel_err   = sub_errAck[idx_q];
  assign sel_rdata = sub_rdata[idx_q*DW +: DW];

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      timer_q       <= '0;
      armed_q       <= 1'b1;
      sub_ABus      <= '0;
      sub_DBus      <= '0;
      sub_BE        <= '0;
      sub_RNW       <= 1'b0;
      xfer_ack_q    <= 1'b0;
      err_ack_q     <= 1'b0;
      rdata_q       <= '0;
      timeout_count <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      armed_q       <= armed_d;
      sub_ABus      <= abus_d;
      sub_DBus      <= dbus_d;
      sub_BE        <= be_d;
      sub_RNW       <= rnw_d;
      xfer_ack_q    <= xfer_ack_d;
      err_ack_q     <= err_ack_d;
      rdata_q       <= rdata_d;
      timeout_count <= tcount_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    // Any cycle with select low re-arms decode, so a held select is never re-decoded
    armed_d    = armed_q | ~opb.OPB_select;
    abus_d     = sub_ABus;
    dbus_d     = sub_DBus;
    be_d       = sub_BE;
    rnw_d      = sub_RNW;
    xfer_ack_d = 1'b0;
    err_ack_d  = 1'b0;
    rdata_d    = '0;
    tcount_d   = tc_load ? tc_load_value : timeout_count;

    case (state_q)
      S_IDLE: begin
        if (opb.OPB_select && armed_q && in_win) begin
          state_d = S_FWD;
          idx_d   = dec_idx;
          timer_d = '0;
          armed_d = 1'b0;
          abus_d  = opb.OPB_ABus;
          dbus_d  = opb.OPB_DBus;
          be_d    = opb.OPB_BE;
          rnw_d   = opb.OPB_RNW;
        end
      end

      S_FWD: begin
        timer_d = timer_q + 8'd1;
        if (!opb.OPB_select) begin
          state_d = S_IDLE;
        end else if (sel_ack) begin
          state_d    = S_DONE;
          xfer_ack_d = 1'b1;
          rdata_d    = sub_RNW ? sel_rdata : '0;
        end else if (sel_err) begin
          state_d   = S_DONE;
          err_ack_d = 1'b1;
        end else if (timer_q == TMO_LAST) begin
          state_d   = S_DONE;
          err_ack_d = 1'b1;
          if (timeout_count != 16'hFFFF) begin
            tcount_d = timeout_count + 16'd1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sub_select     = (state_q == S_FWD) ? (NUM_SLAVES'(1) << idx_q) : '0;
  assign opb.Sl_toutSup = (state_q == S_FWD);
  assign opb.Sl_xferAck = xfer_ack_q;
  assign opb.Sl_errAck  = err_ack_q;
  assign opb.Sl_DBus    = rdata_q;
  assign opb.Sl_retry   = 1'b0;
  assign state_dbg      = state_q;

  // Sequential-address hint is deliberately ignored: every beat is decoded alone
  logic unused_ok;
  assign unused_ok = opb.OPB_seqAddr;

endmodule

// File: tb/tb_opb_slave_window_ctrl.sv
// Directed bench for opb_slave_window_ctrl: decode, read/write forwarding,
// timeout, abort, reset, priority and counter saturation.
module tb_opb_slave_window_ctrl;

  logic         OPB_Clk = 1'b0;
  logic         OPB_Rst = 1'b1;
  logic [3:0]   sub_select;
  logic [0:31]  sub_ABus;
  logic [0:31]  sub_DBus;
  logic [0:3]   sub_BE;
  logic         sub_RNW;
  logic [127:0] sub_rdata;
  logic [3:0]   sub_xferAck;
  logic [3:0]   sub_errAck;
  logic [15:0]  timeout_count;
  logic         tc_load;
  logic [15:0]  tc_load_value;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] acc;

  opb_slave_window_ctrl_if #(.AW(32), .DW(32)) opb ();

  opb_slave_window_ctrl dut (
    .OPB_Clk       (OPB_Clk),
    .OPB_Rst       (OPB_Rst),
    .opb           (opb),
    .sub_select    (sub_select),
    .sub_ABus      (sub_ABus),
    .sub_DBus      (sub_DBus),
    .sub_BE        (sub_BE),
    .sub_RNW       (sub_RNW),
    .sub_rdata     (sub_rdata),
    .sub_xferAck   (sub_xferAck),
    .sub_errAck    (sub_errAck),
    .timeout_count (timeout_count),
    .tc_load       (tc_load),
    .tc_load_value (tc_load_value),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  always #5 OPB_Clk = ~OPB_Clk;

  task automatic tick();
    @(posedge OPB_Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic start_xfer(input logic [31:0] addr, input logic rnw, input logic [31:0] data);
    opb.OPB_ABus   = addr;
    opb.OPB_RNW    = rnw;
    opb.OPB_DBus   = data;
    opb.OPB_BE     = 4'hF;
    opb.OPB_select = 1'b1;
  endtask

  task automatic end_xfer();
    opb.OPB_select = 1'b0;
    sub_xferAck    = '0;
    sub_errAck     = '0;
    tick();
  endtask

  task automatic load_count(input logic [15:0] v);
    tc_load       = 1'b1;
    tc_load_value = v;
    tick();
    tc_load       = 1'b0;
  endtask

  function automatic logic [31:0] activity();
    return {26'd0, state_dbg, opb.Sl_toutSup, opb.Sl_errAck, opb.Sl_xferAck, |sub_select};
  endfunction

  initial begin
    opb.OPB_ABus    = '0;
    opb.OPB_BE      = '0;
    opb.OPB_DBus    = '0;
    opb.OPB_RNW     = 1'b0;
    opb.OPB_select  = 1'b0;
    opb.OPB_seqAddr = 1'b0;
    sub_rdata       = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    sub_xferAck     = '0;
    sub_errAck      = '0;
    tc_load         = 1'b0;
    tc_load_value   = '0;

    repeat (3) tick();
    check("rst_xferack", opb.Sl_xferAck, 0);
    check("rst_errack", opb.Sl_errAck, 0);
    check("rst_dbus", opb.Sl_DBus, 0);
    check("rst_toutsup", opb.Sl_toutSup, 0);
    check("rst_retry", opb.Sl_retry, 0);
    check("rst_subsel", sub_select, 0);
    check("rst_tcount", timeout_count, 0);
    check("rst_state", state_dbg, 0);
    OPB_Rst = 1'b0;
    tick();

    // read slave 2, ack in third selected cycle, stray ack from slave 1 ignored
    start_xfer(32'h0108C204, 1'b1, 32'h0);
    sub_rdata[64 +: 32] = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    tick();
    check("rd_subsel", sub_select, 4'b0100);
    check("rd_toutsup", opb.Sl_toutSup, 1);
    check("rd_subabus", sub_ABus, 32'h0108C204);
    check("rd_subrnw", sub_RNW, 1);
    sub_xferAck = 4'b0010;
    tick();
    check("rd_stray_ignored", opb.Sl_xferAck, 0);
    sub_xferAck = 4'b0000;
    tick();
    sub_xferAck = 4'b0100;
    check("rd_dbus_before", opb.Sl_DBus, 0);
    tick();
    sub_xferAck = 4'b0000;
    check("rd_xferack", opb.Sl_xferAck, 1);
    check("rd_data", opb.Sl_DBus, exp_q.pop_front());
    check("rd_subsel_done", sub_select, 0);
    opb.OPB_select = 1'b0;
    tick();
    check("rd_ack_pulse", opb.Sl_xferAck, 0);
    check("rd_dbus_after", opb.Sl_DBus, 0);

    // write slave 0; select held afterwards must not re-decode
    start_xfer(32'h0108C000, 1'b0, 32'h12345678);
    sub_rdata[0 +: 32] = 32'hFFFFFFFF;
    tick();
    check("wr_subsel", sub_select, 4'b0001);
    check("wr_subdbus", sub_DBus, 32'h12345678);
    check("wr_subrnw", sub_RNW, 0);
    check("wr_subbe", sub_BE, 4'hF);
    sub_xferAck = 4'b0001;
    tick();
    sub_xferAck = 4'b0000;
    check("wr_xferack", opb.Sl_xferAck, 1);
    check("wr_dbus_zero", opb.Sl_DBus, 0);
    acc = 0;
    repeat (3) begin
      tick();
      acc |= activity();
    end
    check("wr_held_no_redecode", acc, 0);
    end_xfer();

    // timeout on slave 1
    start_xfer(32'h0108C100, 1'b1, 32'h0);
    acc = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      acc |= {30'd0, opb.Sl_errAck, opb.Sl_xferAck};
      if (k == 1) check("to_subsel", sub_select, 4'b0010);
    end
    check("to_no_early_ack", acc, 0);
    check("to_toutsup_16", opb.Sl_toutSup, 1);
    tick();
    check("to_errack_17", opb.Sl_errAck, 1);
    check("to_no_xferack", opb.Sl_xferAck, 0);
    check("to_count", timeout_count, 1);
    check("to_subsel_drop", sub_select, 0);
    end_xfer();
    check("to_errack_pulse", opb.Sl_errAck, 0);

    // out of window above and below
    start_xfer(32'h0108D000, 1'b1, 32'h0);
    acc = 0;
    repeat (40) begin
      tick();
      acc |= activity();
    end
    check("oow_above", acc, 0);
    opb.OPB_ABus = 32'h0108BFFC;
    acc = 0;
    repeat (5) begin
      tick();
      acc |= activity();
    end
    check("oow_below", acc, 0);
    end_xfer();

    // last word of window hits slave 3, then master abort
    start_xfer(32'h0108C3FC, 1'b1, 32'h0);
    tick();
    check("top_subsel", sub_select, 4'b1000);
    opb.OPB_select = 1'b0;
    acc = 0;
    repeat (3) begin
      tick();
      acc |= activity();
    end
    check("abort_quiet", acc, 0);

    // reset while forwarding
    start_xfer(32'h0108C204, 1'b0, 32'hA5A5A5A5);
    tick();
    check("rstfwd_toutsup", opb.Sl_toutSup, 1);
    OPB_Rst = 1'b1;
    opb.OPB_select = 1'b0;
    tick();
    check("rstfwd_subsel", sub_select, 0);
    check("rstfwd_subabus", sub_ABus, 0);
    check("rstfwd_subdbus", sub_DBus, 0);
    check("rstfwd_toutsup0", opb.Sl_toutSup, 0);
    check("rstfwd_acks", {opb.Sl_xferAck, opb.Sl_errAck}, 0);
    check("rstfwd_state", state_dbg, 0);
    check("rstfwd_count", timeout_count, 0);
    OPB_Rst = 1'b0;
    tick();

    // xferAck in the timeout cycle wins, count unchanged
    start_xfer(32'h0108C010, 1'b1, 32'h0);
    sub_rdata[0 +: 32] = 32'hCAFEF00D;
    exp_q.push_back(32'hCAFEF00D);
    repeat (16) tick();
    sub_xferAck = 4'b0001;
    tick();
    check("pri_xferack", opb.Sl_xferAck, 1);
    check("pri_no_errack", opb.Sl_errAck, 0);
    check("pri_data", opb.Sl_DBus, exp_q.pop_front());
    check("pri_count", timeout_count, 0);
    end_xfer();

    // xferAck beats errAck in the same cycle
    start_xfer(32'h0108C300, 1'b0, 32'h0);
    tick();
    sub_xferAck = 4'b1000;
    sub_errAck  = 4'b1000;
    tick();
    check("xe_xferack", opb.Sl_xferAck, 1);
    check("xe_errack", opb.Sl_errAck, 0);
    end_xfer();

    // errAck alone, not counted as timeout
    start_xfer(32'h0108C100, 1'b1, 32'h0);
    tick();
    sub_errAck = 4'b0010;
    tick();
    check("err_errack", opb.Sl_errAck, 1);
    check("err_xferack", opb.Sl_xferAck, 0);
    check("err_count", timeout_count, 0);
    end_xfer();

    // counter saturation
    load_count(16'hFFFE);
    check("sat_load", timeout_count, 16'hFFFE);
    for (int t = 0; t < 2; t++) begin
      start_xfer(32'h0108C200, 1'b1, 32'h0);
      repeat (17) tick();
      check("sat_errack", opb.Sl_errAck, 1);
      check("sat_count", timeout_count, 16'hFFFF);
      end_xfer();
    end

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
